// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan path: hex font, digit count,
// segment bit order and the leading-zero helper.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  // Bit positions inside the 8-bit segment bus; DP sits above g..a.
  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_bit_e;

  localparam int unsigned SEG_DP_BIT = 7;

  // Active-high g..a patterns for hex digits 0..F.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // True when digit k and every digit above it are zero; digit 0 never qualifies.
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] k);
    logic res;
    res = 1'b0;
    unique case (k)
      2'd3: res = (v[15:12] == 4'h0);
      2'd2: res = (v[15:8] == 8'h00);
      2'd1: res = (v[15:4] == 12'h000);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex digit to active-high 7-segment (g..a) decoder.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_FONT[digit];
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit multiplexed 7-segment driver with PWM dimming, leading-zero
// blanking and frame-synchronous double-buffered value updates.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned DIV_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        blank_lz,
  input  logic [3:0]  brightness,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_start,
  output logic [3:0]  io_sel,
  output logic [7:0]  io_seg
);

  logic [DIV_BITS-1:0] div_cnt;
  logic [1:0]          idx;
  logic [15:0]         pend_value;
  logic [3:0]          pend_dp;
  logic                pend_valid;
  logic [15:0]         disp_value;
  logic [3:0]          disp_dp;

  logic       wrap;
  logic       boundary;
  logic       lit;
  logic       blank;
  logic [3:0] cur_digit;
  logic [6:0] font_seg;
  logic [3:0] sel_nxt;
  logic [7:0] seg_nxt;

  assign wrap     = &div_cnt;
  assign boundary = wrap && (idx == 2'd3);

  // A load on the boundary cycle lands in pending while the older pending
  // value moves to the display, so pend_valid must stay set in that case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      idx         <= '0;
      pend_value  <= '0;
      pend_dp     <= '0;
      pend_valid  <= 1'b0;
      disp_value  <= '0;
      disp_dp     <= '0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      if (wrap) idx <= idx + 2'd1;
      if (boundary && pend_valid) begin
        disp_value <= pend_value;
        disp_dp    <= pend_dp;
      end
      if (load) begin
        pend_value <= value;
        pend_dp    <= dp;
        pend_valid <= 1'b1;
      end else if (boundary) begin
        pend_valid <= 1'b0;
      end
      load_ack    <= boundary && pend_valid;
      frame_start <= boundary;
    end
  end

  assign cur_digit = disp_value[{idx, 2'b00} +: 4];

  seg_decoder u_dec (
    .digit (cur_digit),
    .seg   (font_seg)
  );

  assign lit   = (div_cnt[DIV_BITS-1 -: 4] < brightness);
  assign blank = blank_lz && lz_blank(disp_value, idx);

  always_comb begin
    sel_nxt = '1;
    seg_nxt = '1;
    if (lit) begin
      sel_nxt = ~(4'b0001 << idx);
      seg_nxt = ~{disp_dp[idx], (blank ? 7'h00 : font_seg)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_sel <= '1;
      io_seg <= '1;
    end else begin
      io_sel <= sel_nxt;
      io_seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed self-checking bench for seg_scan_mux with DIV_BITS = 6
// (64-cycle dwell, 256-cycle frame).
module tb_seg_scan_mux;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        blank_lz;
  logic [3:0]  brightness;
  logic        load;
  logic        load_ack;
  logic        frame_start;
  logic [3:0]  io_sel;
  logic [7:0]  io_seg;

  int checks = 0;
  int errors = 0;
  int cyc;
  int ack_cnt = 0;

  seg_scan_mux #(.DIV_BITS(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .dp          (dp),
    .blank_lz    (blank_lz),
    .brightness  (brightness),
    .load        (load),
    .load_ack    (load_ack),
    .frame_start (frame_start),
    .io_sel      (io_sel),
    .io_seg      (io_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc == n after the n-th rising edge since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (load_ack === 1'b1) ack_cnt <= ack_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) chk("goto_cycle", cyc, n);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    int base;
    int cnt;
    rst_n      = 1'b0;
    value      = '0;
    dp         = '0;
    blank_lz   = 1'b0;
    brightness = 4'd15;
    load       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sel", io_sel, 4'hF);
    chk("rst_seg", io_seg, 8'hFF);
    chk("rst_ack", load_ack, 1'b0);
    chk("rst_fs", frame_start, 1'b0);
    rst_n = 1'b1;

    // Idle scan after reset: display 0000, full brightness.
    goto(1);   chk("scan_d0_sel", io_sel, 4'b1110); chk("scan_d0_seg", io_seg, 8'hC0);
    goto(61);  chk("pwm_dark_sel", io_sel, 4'hF);   chk("pwm_dark_seg", io_seg, 8'hFF);
    goto(65);  chk("scan_d1_sel", io_sel, 4'b1101);
    goto(129); chk("scan_d2_sel", io_sel, 4'b1011);
    goto(193); chk("scan_d3_sel", io_sel, 4'b0111); chk("scan_d3_seg", io_seg, 8'hC0);
    goto(255); chk("fs_before", frame_start, 1'b0);
    goto(256); chk("fs_first", frame_start, 1'b1);
    goto(257); chk("fs_after", frame_start, 1'b0);

    // Mid-frame load of 1234 with dp on digit 0.
    goto(300); do_load(16'h1234, 4'b0001);
    goto(310); chk("pre_bnd_seg", io_seg, 8'hC0);
    goto(511); chk("ack_before", load_ack, 1'b0);
    goto(512); chk("ack_pulse", load_ack, 1'b1); chk("fs_second", frame_start, 1'b1);
    goto(513); chk("ack_after", load_ack, 1'b0);
    chk("v1234_d0_sel", io_sel, 4'b1110); chk("v1234_d0_seg", io_seg, 8'h19);
    goto(577); chk("v1234_d1_seg", io_seg, 8'hB0);
    goto(641); chk("v1234_d2_seg", io_seg, 8'hA4);
    goto(705); chk("v1234_d3_seg", io_seg, 8'hF9);

    // Two loads in one frame: newest wins, single ack.
    goto(800); base = ack_cnt; do_load(16'hAAAA, 4'b0000);
    goto(850); do_load(16'h0008, 4'b0000);
    goto(1024); chk("dbl_ack", load_ack, 1'b1);
    goto(1025); chk("dbl_d0_seg", io_seg, 8'h80);
    goto(1089); chk("dbl_d1_seg", io_seg, 8'hC0);
    goto(1100); chk("dbl_ack_count", ack_cnt - base, 1);

    // Leading-zero blanking applied live.
    blank_lz = 1'b1;
    goto(1153); chk("lz_d2_sel", io_sel, 4'b1011); chk("lz_d2_seg", io_seg, 8'hFF);
    goto(1217); chk("lz_d3_seg", io_seg, 8'hFF);
    goto(1281); chk("lz_d0_seg", io_seg, 8'h80);
    goto(1345); chk("lz_d1_seg", io_seg, 8'hFF);

    // All-zero value: digit 0 still shows "0"; blanked digit 1 keeps its dp.
    goto(1350); do_load(16'h0000, 4'b0010);
    goto(1536); chk("zero_ack", load_ack, 1'b1);
    goto(1537); chk("zero_d0_seg", io_seg, 8'hC0);
    goto(1601); chk("zero_d1_dp_seg", io_seg, 8'h7F);

    // Load coinciding with the boundary: older pending shows now, new one next frame.
    goto(1700); do_load(16'h5678, 4'b0000);
    goto(1791); do_load(16'h0008, 4'b0000);
    goto(1792); chk("coin_ack1", load_ack, 1'b1);
    goto(1857); chk("coin_d1_seg", io_seg, 8'hF8);
    goto(2048); chk("coin_ack2", load_ack, 1'b1);
    goto(2113); chk("coin_next_d1_seg", io_seg, 8'hFF);

    // Brightness 0: dark for a whole dwell; brightness 8: lit exactly half.
    goto(2150); brightness = 4'd0;
    goto(2177);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      if (io_sel !== 4'hF) cnt++;
      @(negedge clk);
    end
    chk("bright0_lit_cycles", cnt, 0);
    goto(2250); brightness = 4'd8;
    goto(2305);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      if (io_sel === 4'b1110) cnt++;
      @(negedge clk);
    end
    chk("bright8_lit_cycles", cnt, 32);

    // Reset with a load pending: discarded, no ack afterwards.
    brightness = 4'd15;
    blank_lz   = 1'b0;
    goto(2400); do_load(16'h1111, 4'b1111);
    goto(2450);
    base  = ack_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", io_sel, 4'hF);
    chk("mid_rst_seg", io_seg, 8'hFF);
    chk("mid_rst_ack", load_ack, 1'b0);
    chk("mid_rst_fs", frame_start, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto(1);   chk("post_rst_sel", io_sel, 4'b1110); chk("post_rst_seg", io_seg, 8'hC0);
    goto(256); chk("post_rst_fs", frame_start, 1'b1); chk("post_rst_ack", load_ack, 1'b0);
    goto(300); chk("post_rst_ack_count", ack_cnt - base, 0);
    goto(321); chk("post_rst_d1_seg", io_seg, 8'hC0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed no finish expected finish by 200000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter DIV_BITS, default 16, sets the digit dwell to 2^DIV_BITS clk cycles; legal range 6..24.
REQ-002 Port clk, input, 1, system clock (100 MHz on board).
REQ-003 Port rst_n, input, 1, asynchronous reset, active low.
REQ-004 Port value, input, 16, four hex digits; digit0 = value[3:0] (rightmost), digit3 = value[15:12].
REQ-005 Port dp, input, 4, decimal point per digit; dp[i] belongs to digit i; 1 = lit.
REQ-006 Port blank_lz, input, 1, 1 = suppress leading zeros.
REQ-007 Port brightness, input, 4, PWM duty level, 0 = dark, 15 = 15/16 on.
REQ-008 Port load, input, 1, single-cycle strobe that captures value and dp.
REQ-009 Port load_ack, output, 1, one-cycle pulse when a captured load becomes visible.
REQ-010 Port frame_start, output, 1, one-cycle pulse at the start of each 4-digit frame.
REQ-011 Port io_sel, output, 4, digit enables, active low; io_sel[i] drives digit i.
REQ-012 Port io_seg, output, 8, segments, active low; bit7 = dp, bits 6..0 = g..a.

Function
REQ-013 Free-running counter div_cnt (DIV_BITS wide) increments every clk and wraps to 0.
REQ-014 Digit index idx (2 bits) advances mod 4 on the cycle div_cnt wraps (all-ones -> 0).
REQ-015 Frame boundary = cycle where div_cnt is all ones and idx == 3.
REQ-016 On load, value/dp are written into a pending register and pending_valid is set.
REQ-017 Load while pending_valid is already set overwrites pending; newest wins; no error flag.
REQ-018 At a frame boundary with pending_valid set: display register <= pending, pending_valid cleared, load_ack = 1 the next cycle.
REQ-019 Load coinciding with a frame boundary: the load is captured into pending and applied at the following boundary; any earlier pending value is displayed now.
REQ-020 frame_start = 1 on the cycle after every frame boundary, regardless of load activity.
REQ-021 Outputs are registered: io_sel/io_seg reflect idx/div_cnt one cycle later.
REQ-022 Digit i is lit only when div_cnt[DIV_BITS-1 -: 4] < brightness; otherwise io_sel = 4'hF and io_seg = 8'hFF.
REQ-023 When lit, io_sel = one-cold for idx (idx 0 -> 4'b1110) and io_seg = ~{dp[idx], font(digit idx)}.
REQ-024 Hex font covers 0..F; active-high examples: 0 = 7'h3F, 8 = 7'h7F, F = 7'h71.
REQ-025 Leading-zero blank (blank_lz = 1): digit k in 3..1 blanks its segments a..g if it and all higher digits are zero; digit0 never blanks.
REQ-026 A blanked digit still shows its dp bit.
REQ-027 brightness and blank_lz are sampled live, not through the load path.

Reset
REQ-028 rst_n low: div_cnt = 0, idx = 0, display = 0, dp = 0, pending_valid = 0 -- asynchronously.
REQ-029 rst_n low: io_sel = 4'hF, io_seg = 8'hFF, load_ack = 0, frame_start = 0.
REQ-030 Reset mid-frame discards any pending load; no load_ack is issued for it.
REQ-031 After release, the first frame boundary occurs 4*2^DIV_BITS cycles later.

Structure
REQ-032 A shared package seg_pkg holds the 16-entry hex font constants, NUM_DIGITS = 4, and the segment bit-order definition.
REQ-033 One combinational sub-module seg_decoder maps a 4-bit digit to 7 active-high segments; seg_scan_mux instantiates it once on the muxed digit.

Verification (DIV_BITS = 6)
REQ-034 Reset, brightness = 15, no load -> io_sel cycles 1110, 1101, 1011, 0111 every 64 cycles; lit io_seg = 8'hC0; frame_start pulses every 256 cycles.
REQ-035 load with value = 16'h1234 and dp = 4'b0001 mid-frame -> display unchanged until the boundary; load_ack one cycle after it; digit0 io_seg = 8'h19 (4 with dp).
REQ-036 Two loads 16'hAAAA then 16'h0008 in one frame -> only 16'h0008 is shown; one load_ack.
REQ-037 Value 16'h0008 with blank_lz = 1 -> digits 3..1 io_seg = 8'hFF; digit0 = 8'h80; digit 0000 with blank_lz shows "0" on digit0.
REQ-038 brightness = 0 -> io_sel stays 4'hF; brightness = 8 -> each digit lit exactly 32 of 64 dwell cycles.
REQ-039 Load then assert rst_n low before the boundary -> outputs at reset values, display = 0, no load_ack after release.
